// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants and serializer state encoding
package matmul_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int MAX_N  = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND_HI,
    S_ACK_HI,
    S_DRAIN_HI,
    S_SEND_LO,
    S_ACK_LO,
    S_DRAIN_LO,
    S_FINISH
  } ser_state_t;

  // Element count of an N x N matrix; 15*15 = 225 still fits in 8 bits.
  function automatic logic [7:0] elem_count(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'd0, n};
    return n8 * n8;
  endfunction

endpackage

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - streams the N x N result matrix to the UART, MSB byte first
module result_serializer
  import matmul_pkg::*;
#(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int ADDR_W = matmul_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done
);

  ser_state_t        state, state_n;
  logic              start_q;
  logic              start_edge;
  logic [7:0]        idx;
  logic [7:0]        total;
  logic [DATA_W-1:0] word_q;
  logic [7:0]        tx_q;
  logic              last_elem;

  assign start_edge = start & ~start_q;
  assign last_elem  = (idx == total - 8'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Frame bookkeeping: edge detector, element counter, fetched word, last sent byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      idx     <= '0;
      total   <= '0;
      word_q  <= '0;
      tx_q    <= '0;
    end else begin
      // start_q tracks in every state so a level held past FINISH is not a new edge
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            total <= elem_count(matrix_size);
            idx   <= '0;
          end
        end
        S_LATCH:    word_q <= rd_data;
        S_DRAIN_LO: if (!tx_busy && !last_elem) idx <= idx + 8'd1;
        default: ;
      endcase
      if (tx_send) tx_q <= tx_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start_edge) state_n = (matrix_size == 4'd0) ? S_FINISH : S_FETCH;
      end
      S_FETCH:    state_n = S_LATCH;
      S_LATCH:    state_n = S_SEND_HI;
      S_SEND_HI:  if (!tx_busy) state_n = S_ACK_HI;
      S_ACK_HI:   if (tx_busy)  state_n = S_DRAIN_HI;
      S_DRAIN_HI: if (!tx_busy) state_n = S_SEND_LO;
      S_SEND_LO:  if (!tx_busy) state_n = S_ACK_LO;
      S_ACK_LO:   if (tx_busy)  state_n = S_DRAIN_LO;
      S_DRAIN_LO: if (!tx_busy) state_n = last_elem ? S_FINISH : S_FETCH;
      S_FINISH:   state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Outputs; tx_data shows the pending byte in SEND and holds the sent byte afterwards
  always_comb begin
    rd_addr = ADDR_W'(idx);
    rd_en   = (state == S_FETCH);
    tx_send = ((state == S_SEND_HI) || (state == S_SEND_LO)) && !tx_busy;
    busy    = (state != S_IDLE) && (state != S_FINISH);
    done    = (state == S_FINISH);
    case (state)
      S_SEND_HI: tx_data = word_q[DATA_W-1 -: 8];
      S_SEND_LO: tx_data = word_q[7:0];
      default:   tx_data = tx_q;
    endcase
  end

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed self-checking bench for result_serializer
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  matrix_size = 4'd0;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic [15:0] rd_data = 16'd0;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        busy;
  logic        done;

  result_serializer dut (
    .clk(clk), .rst(rst), .start(start), .matrix_size(matrix_size),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  rx_q[$];
  int          hold = 10;
  int          cnt = 0;
  logic        force_busy = 1'b0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          viol = 0;
  int          last_addr = 0;

  // Result buffer: data one cycle after the read strobe
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // UART: busy rises the cycle after tx_send and stays up for hold cycles
  always @(posedge clk) begin
    if (tx_send) cnt <= hold;
    else if (cnt != 0) cnt <= cnt - 1;
  end
  assign tx_busy = (cnt != 0) || force_busy;

  // Observation away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_send) begin
        rx_q.push_back(tx_data);
        if (tx_busy) viol++;
      end
      if (rd_en) begin
        rd_cnt++;
        last_addr = int'(rd_addr);
      end
      if (done) begin
        done_cnt++;
        if (busy) viol++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    rx_q.delete();
    done_cnt = 0;
    rd_cnt = 0;
    viol = 0;
    last_addr = 0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  function automatic int byte_errs(input int n);
    int e = 0;
    for (int k = 0; k < n * n; k++) begin
      if (rx_q.size() <= 2 * k + 1) begin
        e++;
      end else begin
        if (rx_q[2*k]   !== mem[k][15:8]) e++;
        if (rx_q[2*k+1] !== mem[k][7:0])  e++;
      end
    end
    return e;
  endfunction

  task automatic load_fixed();
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
  endtask

  typedef struct {
    int n;
    int hold_c;
    int pre_busy;
    int exp_bytes;
    int exp_last_addr;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] fixed_exp [8];

  initial begin
    bit ok;
    int got;

    vecs[0] = '{2, 10, 0, 8, 3};
    vecs[1] = '{1, 1, 0, 2, 0};
    vecs[2] = '{3, 2, 0, 18, 8};
    vecs[3] = '{15, 1, 0, 450, 224};
    vecs[4] = '{4, 3, 1, 32, 15};
    fixed_exp = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;

    // Reset state
    #12;
    check("rst_rd_en",   int'(rd_en),   0);
    check("rst_tx_send", int'(tx_send), 0);
    check("rst_busy",    int'(busy),    0);
    check("rst_done",    int'(done),    0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_tx_data", int'(tx_data), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      clear_obs();
      if (v == 0) load_fixed();
      else for (int i = 0; i < 225; i++) mem[i] = 16'($urandom);
      hold = vecs[v].hold_c;
      matrix_size = 4'(vecs[v].n);
      force_busy = (vecs[v].pre_busy != 0);
      pulse_start();
      matrix_size = 4'(vecs[v].n ^ 5);
      @(negedge clk); #1;
      check($sformatf("v%0d_busy_mid", v), int'(busy), 1);
      if (vecs[v].pre_busy != 0) begin
        repeat (20) @(posedge clk);
        #1;
        check($sformatf("v%0d_held_off", v), rx_q.size(), 0);
        force_busy = 1'b0;
      end
      wait_done(0, 20000, ok);
      check($sformatf("v%0d_done_seen", v), int'(ok), 1);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_nbytes", v), rx_q.size(), vecs[v].exp_bytes);
      check($sformatf("v%0d_byte_errs", v), byte_errs(vecs[v].n), 0);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last_addr);
      check($sformatf("v%0d_protocol", v), viol, 0);
      check($sformatf("v%0d_busy_after", v), int'(busy), 0);
      if (v == 0) begin
        for (int k = 0; k < 8; k++)
          if (rx_q.size() > k)
            check($sformatf("v0_byte%0d", k), int'(rx_q[k]), int'(fixed_exp[k]));
      end
    end

    // N = 0: immediate done, no traffic
    clear_obs();
    matrix_size = 4'd0;
    got = -1;
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done && got < 0) got = k;
    end
    start = 1'b0;
    check("n0_done_latency", int'(got >= 1 && got <= 2), 1);
    check("n0_done_cnt", done_cnt, 1);
    check("n0_reads", rd_cnt, 0);
    check("n0_sends", rx_q.size(), 0);

    // start held through the frame with a second edge mid-frame, then a new edge
    clear_obs();
    load_fixed();
    hold = 4;
    matrix_size = 4'd2;
    @(posedge clk); #1 start = 1'b1;
    repeat (15) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    wait_done(0, 2000, ok);
    check("held_done_seen", int'(ok), 1);
    repeat (20) @(posedge clk);
    #1;
    check("held_done_cnt", done_cnt, 1);
    check("held_nbytes", rx_q.size(), 8);
    check("held_reads", rd_cnt, 4);
    start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    wait_done(1, 2000, ok);
    check("second_done_seen", int'(ok), 1);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("second_nbytes", rx_q.size(), 16);
    check("second_done_cnt", done_cnt, 2);
    check("second_byte8", (rx_q.size() > 8) ? int'(rx_q[8]) : -1, 8'h12);
    check("held_protocol", viol, 0);

    // Async reset during the third byte
    clear_obs();
    hold = 10;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (rx_q.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_mid_reached", int'(ok), 1);
    rst = 1'b1;
    #1;
    check("rstmid_rd_en",   int'(rd_en),   0);
    check("rstmid_tx_send", int'(tx_send), 0);
    check("rstmid_busy",    int'(busy),    0);
    check("rstmid_done",    int'(done),    0);
    check("rstmid_rd_addr", int'(rd_addr), 0);
    check("rstmid_tx_data", int'(tx_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("rstmid_no_done", done_cnt, 0);
    clear_obs();
    pulse_start();
    wait_done(0, 2000, ok);
    check("rerun_done_seen", int'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check("rerun_first_byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 8'h12);
    check("rerun_nbytes", rx_q.size(), 8);
    check("rerun_byte_errs", byte_errs(2), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
